// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor. A start request captures the operands, after
// which one difference bit is produced per clock, LSB first, using a single
// full-subtractor cell and a borrow flop. After WIDTH shift cycles the result
// and the final borrow are loaded into the output registers, and done pulses
// for one cycle.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset
//   start      : request a subtraction (accepted in IDLE and DONE)
//   a          : minuend, unsigned, WIDTH bits
//   b          : subtrahend, unsigned, WIDTH bits
//   diff       : registered result, (a - b) mod 2^WIDTH
//   borrow_out : registered final borrow, 1 when a < b
//   busy       : high while an operation is in progress (SHIFT and DONE)
//   done       : one-cycle pulse marking diff/borrow_out valid
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy,
    output logic             done
);

    // Counter wide enough to hold WIDTH.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    // One full-subtractor step: returns {borrow_next, difference_bit}.
    function automatic logic [1:0] sub_bit(input logic ai, input logic bi, input logic br);
        logic d;
        logic bn;
        d  = ai ^ bi ^ br;
        bn = (~ai & bi) | (~(ai ^ bi) & br);
        return {bn, d};
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] res_r;
    logic             br_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] diff_r;
    logic             borrow_r;
    logic             busy_r;
    logic             done_r;

    logic [1:0]       step_s;
    logic             d_s;
    logic             br_next_s;
    logic [WIDTH:0]   res_cat_s;
    logic [WIDTH-1:0] res_next_s;
    logic             last_s;
    logic             load_s;

    // Bit-serial datapath: current LSBs through the subtractor cell, and the
    // result register with the new bit entering from the MSB end.
    always_comb begin
        step_s     = sub_bit(a_sh_r[0], b_sh_r[0], br_r);
        d_s        = step_s[0];
        br_next_s  = step_s[1];
        res_cat_s  = {d_s, res_r};
        res_next_s = res_cat_s[WIDTH:1];
        last_s     = (cnt_r == CNT_LAST);
        if ((state_r == IDLE) || (state_r == DONE)) begin
            load_s = start;
        end else begin
            load_s = 1'b0;
        end
    end

    // Next-state logic; start is only honoured in IDLE and DONE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = SHIFT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            DONE: begin
                if (start) begin
                    state_next_s = SHIFT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand shift registers, partial result, borrow flop and bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_r <= {WIDTH{1'b0}};
            b_sh_r <= {WIDTH{1'b0}};
            res_r  <= {WIDTH{1'b0}};
            br_r   <= 1'b0;
            cnt_r  <= CNT_ZERO;
        end else if (load_s) begin
            a_sh_r <= a;
            b_sh_r <= b;
            res_r  <= {WIDTH{1'b0}};
            br_r   <= 1'b0;
            cnt_r  <= CNT_ZERO;
        end else if (state_r == SHIFT) begin
            a_sh_r <= a_sh_r >> 1;
            b_sh_r <= b_sh_r >> 1;
            res_r  <= res_next_s;
            br_r   <= br_next_s;
            cnt_r  <= cnt_r + CNT_ONE;
        end else begin
            a_sh_r <= a_sh_r;
            b_sh_r <= b_sh_r;
            res_r  <= res_r;
            br_r   <= br_r;
            cnt_r  <= cnt_r;
        end
    end

    // Output registers. The result is loaded only on the final shift step, so
    // diff never shows a partially assembled value; busy/done follow the state
    // being entered so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            diff_r   <= {WIDTH{1'b0}};
            borrow_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            busy_r <= (state_next_s != IDLE);
            done_r <= (state_next_s == DONE);
            if ((state_r == SHIFT) && last_s) begin
                diff_r   <= res_next_s;
                borrow_r <= br_next_s;
            end else begin
                diff_r   <= diff_r;
                borrow_r <= borrow_r;
            end
        end
    end

    assign diff       = diff_r;
    assign borrow_out = borrow_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule
